// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window sequencer: FSM state codes and default geometry.
package sobel_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int CW_DEF    = 10;
  localparam int RW_DEF    = 9;

endpackage

// File: rtl/sobel_raster_counter.sv
// Raster position counter: column wraps at IMG_W-1 and advances the row; row wraps at IMG_H-1.
module sobel_raster_counter
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = CW_DEF,
  parameter int RW    = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == CW'(IMG_W - 1));
  assign row_end = (row == RW'(IMG_H - 1));
  assign last    = col_end & row_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the Sobel line buffer: paces pixel writes, tracks window position,
// qualifies interior 3x3 windows and flags end of frame.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start_i, no pixels accepted
//   ST_RUN   | accepting pixels, tracking windows from buf_done_i
//   ST_DRAIN | all pixels written, waiting for the remaining windows
//   ST_DONE  | one-cycle end-of-frame pulse, then back to idle
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int CW        = CW_DEF,
  parameter int RW        = RW_DEF,
  parameter int DRAIN_MAX = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          pix_valid_i,
  output logic          pix_ready_o,
  output logic          buf_we_o,
  input  logic          buf_done_i,
  output logic          win_valid_o,
  output logic [CW-1:0] win_col_o,
  output logic [RW-1:0] win_row_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic          err_o
);

  localparam int            TW     = $clog2(DRAIN_MAX + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(DRAIN_MAX - 1);

  logic [1:0]    state;
  logic          active;
  logic          start_clr;
  logic          done_act;
  logic          out_full;
  logic          drain_abort;
  logic          win_hit;
  logic [TW-1:0] drain_tmr;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic          in_last;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          out_last;

  assign active       = (state == ST_RUN) | (state == ST_DRAIN);
  assign pix_ready_o  = (state == ST_RUN);
  assign buf_we_o     = pix_valid_i & pix_ready_o;
  assign busy_o       = (state != ST_IDLE);
  assign frame_done_o = (state == ST_DONE);
  assign start_clr    = (state == ST_IDLE) & start_i;
  assign done_act     = buf_done_i & active & ~out_full;
  assign drain_abort  = (state == ST_DRAIN) & ~done_act & (drain_tmr <= TW'(1));
  assign win_hit      = done_act & (out_col >= CW'(2)) & (out_row >= RW'(2));

  sobel_raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .RW(RW)) u_in_pos (
    .clk  (clk),
    .rst  (rst),
    .en   (buf_we_o),
    .clr  (start_clr),
    .col  (in_col),
    .row  (in_row),
    .last (in_last)
  );

  sobel_raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .RW(RW)) u_out_pos (
    .clk  (clk),
    .rst  (rst),
    .en   (done_act),
    .clr  (start_clr),
    .col  (out_col),
    .row  (out_row),
    .last (out_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_i) state <= ST_RUN;
        ST_RUN:   if (buf_we_o & in_last) state <= ST_DRAIN;
        ST_DRAIN: if ((done_act & out_last) | out_full | drain_abort) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // out_full remembers that the last window was seen, since the output counter wraps to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_full <= 1'b0;
    end else if (start_clr) begin
      out_full <= 1'b0;
    end else if (done_act & out_last) begin
      out_full <= 1'b1;
    end
  end

  // Down-counter reloaded on every window; it measures idle time since the last buf_done_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_tmr <= '0;
    end else if (start_clr | done_act) begin
      drain_tmr <= T_LOAD;
    end else if (active & (drain_tmr > TW'(1))) begin
      drain_tmr <= drain_tmr - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (start_clr) begin
      err_o <= 1'b0;
    end else if ((start_i & busy_o) | (buf_done_i & active & out_full) | drain_abort) begin
      err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid_o <= 1'b0;
      win_col_o   <= '0;
      win_row_o   <= '0;
    end else begin
      win_valid_o <= win_hit;
      if (win_hit) begin
        win_col_o <= out_col - CW'(1);
        win_row_o <= out_row - RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed/randomized bench for sobel_window_ctrl on a 4x3 image with a 2-cycle echo buffer model.
module tb_sobel_window_ctrl;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int CWB  = 3;
  localparam int RWB  = 2;
  localparam int DMAX = 16;

  typedef struct {
    int col;
    int row;
  } coord_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           pix_valid_i;
  logic           pix_ready_o;
  logic           buf_we_o;
  logic           buf_done_i;
  logic           win_valid_o;
  logic [CWB-1:0] win_col_o;
  logic [RWB-1:0] win_row_o;
  logic           busy_o;
  logic           frame_done_o;
  logic           err_o;

  always #5 clk = ~clk;

  sobel_window_ctrl #(
    .IMG_W(W), .IMG_H(H), .CW(CWB), .RW(RWB), .DRAIN_MAX(DMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .buf_we_o     (buf_we_o),
    .buf_done_i   (buf_done_i),
    .win_valid_o  (win_valid_o),
    .win_col_o    (win_col_o),
    .win_row_o    (win_row_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .err_o        (err_o)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  int     cyc = 0;
  int     we_cnt, done_cnt, fd_cnt, fd_cyc, last_done_cyc, ready_gap, echo_limit;
  logic   err_after_start;
  logic   d1, d2, echo_next;
  coord_t got_q[$];
  coord_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive after the rising edge, sample on the falling edge.
  task automatic cycle(input logic sv, input logic pv, input logic inj);
    coord_t c;
    @(posedge clk); #1;
    start_i     = sv;
    pix_valid_i = pv;
    d2          = d1;
    d1          = echo_next;
    buf_done_i  = d2 | inj;
    @(negedge clk);
    echo_next = 1'b0;
    if (buf_we_o === 1'b1) begin
      we_cnt++;
      echo_next = (we_cnt <= echo_limit);
    end
    if (buf_done_i) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (win_valid_o === 1'b1) begin
      c.col = int'(win_col_o);
      c.row = int'(win_row_o);
      got_q.push_back(c);
    end
    if (frame_done_o === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (busy_o === 1'b1 && pix_ready_o !== 1'b1 && we_cnt < W * H) ready_gap++;
    cyc++;
  endtask

  task automatic clear_mon();
    we_cnt = 0; done_cnt = 0; fd_cnt = 0; fd_cyc = -1; last_done_cyc = -1; ready_gap = 0;
    got_q.delete();
  endtask

  // mode 0: pix_valid held high, 1: alternating, 2: random
  task automatic run_frame(input int mode, input int echo_n, input int mid_start_at);
    logic pv;
    clear_mon();
    echo_limit = echo_n;
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 400 && fd_cnt == 0; k++) begin
      if (mode == 0)      pv = 1'b1;
      else if (mode == 1) pv = (k % 2 == 0);
      else                pv = 1'($urandom_range(0, 1));
      cycle(k == mid_start_at, pv, 1'b0);
      if (k == 0) err_after_start = err_o;
    end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int echo_n, input logic exp_err);
    int n;
    exp_q.delete();
    for (int i = 0; i < echo_n; i++) begin
      coord_t c;
      if ((i % W) >= 2 && (i / W) >= 2) begin
        c.col = (i % W) - 1;
        c.row = (i / W) - 1;
        exp_q.push_back(c);
      end
    end
    chk({tag, ".writes"}, we_cnt, W * H);
    chk({tag, ".dones"}, done_cnt, echo_n);
    chk({tag, ".win_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ".win_col"}, got_q[i].col, exp_q[i].col);
      chk({tag, ".win_row"}, got_q[i].row, exp_q[i].row);
    end
    chk({tag, ".frame_done_count"}, fd_cnt, 1);
    chk({tag, ".frame_done_delay"}, fd_cyc - last_done_cyc, (echo_n == W * H) ? 1 : DMAX);
    chk({tag, ".err_after_start"}, err_after_start, 1'b0);
    chk({tag, ".err_end"}, err_o, exp_err);
    chk({tag, ".idle_busy"}, busy_o, 1'b0);
    chk({tag, ".ready_gap"}, ready_gap, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; pix_valid_i = 1'b0; buf_done_i = 1'b0;
    d1 = 1'b0; d2 = 1'b0; echo_next = 1'b0; err_after_start = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("reset.busy", busy_o, 1'b0);
    chk("reset.ready", pix_ready_o, 1'b0);
    chk("reset.win_valid", win_valid_o, 1'b0);
    chk("reset.frame_done", frame_done_o, 1'b0);
    chk("reset.err", err_o, 1'b0);
    chk("reset.win_col", win_col_o, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, W * H, -1);
    check_frame("full", W * H, 1'b0);
    chk("full.hold_col", win_col_o, 2);
    chk("full.hold_row", win_row_o, 1);

    run_frame(1, W * H, -1);
    check_frame("toggle", W * H, 1'b0);

    run_frame(2, W * H, 5);
    check_frame("mid_start", W * H, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("mid_start.err_sticky", err_o, 1'b1);

    run_frame(0, W * H - 3, -1);
    check_frame("drain_abort", W * H - 3, 1'b1);

    // Reset in the middle of a frame, after the 7th accepted pixel.
    clear_mon();
    echo_limit = W * H;
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 100 && we_cnt < 7; k++) cycle(1'b0, 1'b1, 1'b0);
    chk("rst_mid.pixels", we_cnt, 7);
    rst = 1'b1;
    #1;
    chk("rst_mid.busy", busy_o, 1'b0);
    chk("rst_mid.ready", pix_ready_o, 1'b0);
    chk("rst_mid.we", buf_we_o, 1'b0);
    chk("rst_mid.win_col", win_col_o, 0);
    chk("rst_mid.win_row", win_row_o, 0);
    chk("rst_mid.frame_done", frame_done_o, 1'b0);
    d1 = 1'b0; d2 = 1'b0; echo_next = 1'b0;
    buf_done_i = 1'b0; pix_valid_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fd_cnt = 0;
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    chk("rst_mid.no_frame_done", fd_cnt, 0);

    run_frame(2, W * H, -1);
    check_frame("after_rst", W * H, 1'b0);

    clear_mon();
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, (k % 2 == 0));
    chk("idle_done.win_pulses", got_q.size(), 0);
    chk("idle_done.busy", busy_o, 1'b0);
    chk("idle_done.hold_col", win_col_o, 2);
    run_frame(0, W * H, -1);
    check_frame("after_idle_done", W * H, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
Frame-level sequencer for the Sobel window buffer (line buffer plus 3x3 window modulator). It accepts a raster pixel stream from upstream under a valid/ready handshake. It drives the buffer's write strobe and tracks raster position from the buffer's window-done pulses. It qualifies only windows whose 3x3 neighbourhood lies fully inside the image, reports window-centre coordinates, and signals end of frame to the downstream gradient stage.

Parameters:
IMG_W, 640, image width in pixels (>= 3)
IMG_H, 480, image height in lines (>= 3)
CW, 10, column counter width (2^CW > IMG_W)
RW, 9, row counter width (2^RW > IMG_H)
DRAIN_MAX, 4096, max idle cycles in DRAIN before abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start_i  in  1  one-cycle pulse; begin a frame
pix_valid_i  in  1  upstream pixel valid
pix_ready_o  out  1  controller accepts pixel this cycle
buf_we_o  out  1  write strobe to window buffer (done_i of buffer)
buf_done_i  in  1  window-ready pulse from buffer (done_o of buffer)
win_valid_o  out  1  current buffer window is interior (registered)
win_col_o  out  CW  centre column of qualified window
win_row_o  out  RW  centre row of qualified window
busy_o  out  1  frame in progress
frame_done_o  out  1  one-cycle end-of-frame pulse
err_o  out  1  sticky error flag

Behaviour:
- Reset is asynchronous and active-high on rst. All outputs are 0, state is IDLE, all counters are 0 and err_o is 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE
  - pix_ready_o=0, busy_o=0.
  - start_i -> RUN. Clears in_col, in_row, out_col, out_row and the drain timer. err_o is cleared on this transition.
- RUN
  - pix_ready_o=1, busy_o=1.
  - buf_we_o = pix_valid_i & pix_ready_o (combinational, same cycle).
  - Each accepted pixel advances in_col. At IMG_W-1, in_col wraps to 0 and in_row increments.
  - Acceptance of pixel (IMG_W-1, IMG_H-1) -> DRAIN. pix_ready_o drops on the next cycle.
- Output tracking (RUN and DRAIN)
  - Each buf_done_i advances out_col/out_row with the same wrap rule.
  - On the cycle after buf_done_i, win_valid_o=1 iff the pre-increment out_col>=2 and out_row>=2. It is a 1-cycle pulse.
  - On that same cycle, win_col_o = out_col-1 and win_row_o = out_row-1, using pre-increment values. These hold until the next qualified window.
- DRAIN
  - pix_ready_o=0, busy_o=1. The drain timer counts cycles since the last buf_done_i.
  - The buf_done_i that counts position (IMG_W-1, IMG_H-1) -> DONE, after emitting its win_valid_o.
  - If the timer reaches DRAIN_MAX: set err_o and go to DONE.
- DONE
  - frame_done_o=1 for exactly one cycle, busy_o=1, then -> IDLE.
- Boundary conditions
  - start_i in RUN, DRAIN or DONE is ignored and sets err_o.
  - buf_done_i in IDLE or DONE is ignored; counters are unchanged.
  - buf_done_i while out counters already show a full frame sets err_o.
  - pix_valid_i while pix_ready_o=0 produces no buf_we_o and no counter change.
  - The last pixel acceptance and a buf_done_i on the same cycle are both processed.
  - rst mid-frame returns to IDLE immediately with no frame_done_o. The buffer shares rst, so there is no stale data.
- Width rules
  - Counters compare against IMG_W-1 and IMG_H-1 at CW/RW width.
  - Coordinate outputs never exceed IMG_W-2 / IMG_H-2.
- Latency
  - Pixel to buf_we_o: 0 cycles.
  - buf_done_i to win_valid_o: 1 cycle.
  - Last window to frame_done_o: 1 cycle (the cycle after DONE entry).

Decomposition:
- Shared package sobel_pkg holds:
  - state encoding constants ST_IDLE/ST_RUN/ST_DRAIN/ST_DONE (2-bit);
  - default IMG_W, IMG_H, CW, RW.
- One natural sub-module: sobel_raster_counter (CW/RW params; inputs en and clr; outputs col, row and last). It is instantiated twice, for the input and output positions.

Test Plan:
- IMG_W=4, IMG_H=3; start_i, then 12 pixels with pix_valid_i held high; buffer model echoes buf_done_i 2 cycles after each buf_we_o -> exactly 12 buf_we_o; 2 win_valid_o pulses with (col,row)=(1,1),(2,1); frame_done_o one cycle after the 12th buf_done_i; err_o=0.
- Same frame with pix_valid_i toggling 1/0 -> same 12 writes and 2 qualified windows; pix_ready_o=1 throughout RUN.
- start_i pulsed mid-RUN -> ignored; err_o=1 and stays high until the next start_i from IDLE clears it.
- Buffer model suppresses the final 3 buf_done_i, DRAIN_MAX=16 -> frame_done_o 16 cycles after the last buf_done_i; err_o=1.
- rst asserted after pixel 7 -> state IDLE and all outputs 0 asynchronously; no frame_done_o; a new start_i runs a clean 12-pixel frame.
- buf_done_i injected in IDLE -> no win_valid_o; counters stay 0.
